// File: rtl/cd_multi_divider.sv
// Multi-channel programmable clock divider with glitch-free divisor reload at
// period boundaries and a global sync that restarts all running channels in phase.
module cd_multi_divider #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RESET_DIV = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [N_CH-1:0]                         en,
    input  logic                                    wr_en,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
    input  logic [WIDTH-1:0]                        wr_div,
    input  logic                                    sync,
    output logic [N_CH-1:0]                         clkout,
    output logic [N_CH-1:0]                         tick
);

    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [0:0]       state_q, state_d;
        logic [WIDTH-1:0] sh_q, sh_d;
        logic [WIDTH-1:0] act_q, act_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;

        logic             wr_hit_c;
        logic             running_c;
        logic             last_c;
        logic [WIDTH-1:0] act_m1_c;
        logic [WIDTH:0]   half_c;

        // Per-channel helpers; half is computed one bit wider so act=2**WIDTH-1 cannot wrap.
        always_comb begin
            wr_hit_c  = wr_en && (32'(wr_ch) == 32'(gi));
            running_c = en[gi] && (act_q >= TWO);
            act_m1_c  = act_q - ONE;
            last_c    = (cnt_q == act_m1_c);
            half_c    = ({1'b0, act_q} + (WIDTH+1)'(1)) >> 1;
        end

        // Next-state and output decode for one channel.
        always_comb begin
            state_d = state_q;
            sh_d    = wr_hit_c ? wr_div : sh_q;
            act_d   = act_q;
            cnt_d   = cnt_q;
            clk_d   = clk_q;
            tick_d  = tick_q;

            if (!running_c) begin
                state_d = ST_IDLE;
                act_d   = sh_d;
                cnt_d   = '0;
                clk_d   = 1'b0;
                tick_d  = 1'b0;
            end else if (sync || (state_q == ST_IDLE)) begin
                // Start from idle or phase restart; sync also picks up a pending divisor.
                state_d = ST_RUN;
                if (sync) begin
                    act_d = sh_d;
                end
                cnt_d   = '0;
                clk_d   = 1'b1;
                tick_d  = 1'b0;
            end else begin
                state_d = ST_RUN;
                cnt_d   = last_c ? '0 : (cnt_q + ONE);
                if (last_c) begin
                    act_d = sh_d;
                end
                clk_d   = ({1'b0, cnt_d} < half_c);
                tick_d  = (cnt_d == act_m1_c);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= ST_IDLE;
                sh_q    <= DIV_RST;
                act_q   <= DIV_RST;
                cnt_q   <= '0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                sh_q    <= sh_d;
                act_q   <= act_d;
                cnt_q   <= cnt_d;
                clk_q   <= clk_d;
                tick_q  <= tick_d;
            end
        end

        assign clkout[gi] = clk_q;
        assign tick[gi]   = tick_q;
    end

endmodule

// File: tb/tb_cd_multi_divider.sv
// Directed scoreboard bench for cd_multi_divider: stimulus queues per-cycle
// expected clkout/tick values, a negedge monitor pops and compares them.
module tb_cd_multi_divider;

    localparam int unsigned N_CH  = 3;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CH_W  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   en;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [WIDTH-1:0]  wr_div;
    logic              sync;
    logic [N_CH-1:0]   clkout;
    logic [N_CH-1:0]   tick;

    cd_multi_divider #(.N_CH(N_CH), .WIDTH(WIDTH), .RESET_DIV(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .wr_en  (wr_en),
        .wr_ch  (wr_ch),
        .wr_div (wr_div),
        .sync   (sync),
        .clkout (clkout),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        int   ch;
        int   tid;
        logic clk_e;
        logic tick_e;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   tid    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation that falls due this cycle.
    always @(negedge clk) begin
        for (int k = int'(q.size()) - 1; k >= 0; k--) begin
            if (q[k].cyc <= cyc) begin
                n_chk++;
                if (q[k].cyc != cyc || clkout[q[k].ch] !== q[k].clk_e || tick[q[k].ch] !== q[k].tick_e) begin
                    $display("FAIL t%0d ch%0d cyc%0d: got clkout=%b tick=%b, want clkout=%b tick=%b (due cyc%0d)",
                             q[k].tid, q[k].ch, cyc, clkout[q[k].ch], tick[q[k].ch],
                             q[k].clk_e, q[k].tick_e, q[k].cyc);
                end else begin
                    n_pass++;
                end
                q.delete(k);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue expected outputs for channel ch, starting at the current cycle.
    task automatic push(input int ch, input string cp, input string tp);
        exp_t e;
        for (int j = 0; j < cp.len(); j++) begin
            e.cyc    = cyc + j;
            e.ch     = ch;
            e.tid    = tid;
            e.clk_e  = (cp.getc(j) == 8'h31);
            e.tick_e = (tp.getc(j) == 8'h31);
            q.push_back(e);
        end
    endtask

    task automatic wr(input int ch, input logic [WIDTH-1:0] d);
        wr_en  = 1'b1;
        wr_ch  = CH_W'(ch);
        wr_div = d;
    endtask

    initial begin
        rst = 1'b1; en = '0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; sync = 1'b0;

        // reset state
        tid = 0;
        step();
        for (int c = 0; c < int'(N_CH); c++) push(c, "0", "0");

        // D=4 on ch0
        tid = 1;
        rst = 1'b0; wr(0, 4); step();
        wr_en = 1'b0; en = 3'b001; step();
        push(0, "11001100", "00010001");
        push(1, "00000000", "00000000");
        step(7);

        // D=5 on ch1, D=2 on ch2
        tid = 2;
        wr(1, 5); step();
        wr(2, 2); step();
        wr_en = 1'b0; en = 3'b111; step();
        push(0, "0011001100", "0100010001");
        push(1, "1110011100", "0000100001");
        push(2, "1010101010", "0101010101");
        step(9);

        // reload 4 -> 6 written at cnt=1
        tid = 3;
        step(2);
        wr(0, 6); step();
        wr_en = 1'b0;
        push(0, "00111000111000", "01000001000001");
        step(13);

        // sync aligns ch0 (D=4) and ch1 (D=8); ch2 disabled
        tid = 4;
        wr(1, 8); step();
        wr(0, 4); en = 3'b011; step();
        wr_en = 1'b0; step(2);
        sync = 1'b1; step();
        sync = 1'b0;
        push(0, "1100110011001100", "0001000100010001");
        push(1, "1111000011110000", "0000000100000001");
        push(2, "0000", "0000");
        step(15);

        // D=0 and D=1 keep channel idle; D=3 starts it; D=1 written on wrap stops it
        tid = 5;
        wr(2, 0); step();
        wr_en = 1'b0; en = 3'b111; step();
        push(2, "0000", "0000");
        step(3);
        wr(2, 1); step();
        wr_en = 1'b0;
        push(2, "0000", "0000");
        step(3);
        wr(2, 3); step();
        wr_en = 1'b0;
        push(2, "0110110110", "0001001001");
        step(9);
        wr(2, 1); step();
        wr_en = 1'b0;
        push(2, "1000", "0000");
        step(3);

        // en drop mid-high, out-of-range write ignored, then reset mid-period
        tid = 6;
        step(2);
        en = 3'b110; wr(3, 2); step();
        wr_en = 1'b0;
        push(0, "0000000000000000", "0000000000000000");
        push(1, "1110000111100001", "0000001000000010");
        step(15);
        rst = 1'b1; step();
        for (int c = 0; c < int'(N_CH); c++) push(c, "0", "0");
        rst = 1'b0; en = 3'b010; step();
        push(1, "1010", "0101");
        step(3);

        // largest divisor: high phase must not collapse
        tid = 7;
        wr(0, 32'hFFFF_FFFF); step();
        wr_en = 1'b0; en = 3'b011; step();
        push(0, "1111", "0000");
        step(3);

        for (int w = 0; w < 20 && q.size() != 0; w++) step();
        if (q.size() != 0) begin
            $display("FAIL drain: %0d expectations never checked, want 0", q.size());
            n_chk += int'(q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
